// File: rtl/bcd_digit_accumulator.sv
// Assembles a serial, MSD-first stream of BCD digits into a packed BCD word and
// its unsigned binary value, then holds the result for a valid/ready sink.
module bcd_digit_accumulator #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    digit_valid,
    output logic                    digit_ready,
    input  logic [3:0]              bcd_digit,
    input  logic                    digit_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic [4*NUM_DIGITS-1:0] bcd_packed,
    output logic                    err_invalid,
    output logic                    err_overflow
);

    localparam int unsigned PW    = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int unsigned MW    = BIN_W + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [BIN_W-1:0]  acc_nxt;
    logic [PW-1:0]     pk_nxt;
    logic              inv_nxt, ovf_nxt;
    logic              accept;
    logic              bad_digit;
    logic [3:0]        d;
    logic [MW-1:0]     mul10;

    // State and result registers; handshake outputs follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            bin_out      <= '0;
            bcd_packed   <= '0;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
            digit_ready  <= 1'b1;
            out_valid    <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            bin_out      <= acc_nxt;
            bcd_packed   <= pk_nxt;
            err_invalid  <= inv_nxt;
            err_overflow <= ovf_nxt;
            digit_ready  <= (state_nxt != HOLD);
            out_valid    <= (state_nxt == HOLD);
        end
    end

    // Next-state and datapath update; invalid digits contribute as zero
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        acc_nxt   = bin_out;
        pk_nxt    = bcd_packed;
        inv_nxt   = err_invalid;
        ovf_nxt   = err_overflow;

        accept    = digit_valid && digit_ready;
        bad_digit = (bcd_digit > 4'd9);
        d         = bad_digit ? 4'd0 : bcd_digit;
        mul10     = (MW'(bin_out) << 3) + (MW'(bin_out) << 1);

        case (state)
            IDLE: begin
                if (accept) begin
                    inv_nxt   = bad_digit;
                    ovf_nxt   = 1'b0;
                    acc_nxt   = BIN_W'(d);
                    pk_nxt    = PW'(d);
                    count_nxt = CNT_W'(1);
                    state_nxt = digit_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (bad_digit) begin
                        inv_nxt = 1'b1;
                    end
                    if (count < CNT_W'(NUM_DIGITS)) begin
                        acc_nxt   = BIN_W'(mul10 + MW'(d));
                        pk_nxt    = {bcd_packed[PW-5:0], d};
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                    if (digit_last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Randomized and directed bench for bcd_digit_accumulator against a frame-level model.
module tb_bcd_digit_accumulator;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned PW         = 4 * NUM_DIGITS;

    logic              clk;
    logic              rst_n;
    logic              digit_valid;
    logic              digit_ready;
    logic [3:0]        bcd_digit;
    logic              digit_last;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  bin_out;
    logic [PW-1:0]     bcd_packed;
    logic              err_invalid;
    logic              err_overflow;

    int n_cmp;
    int n_err;

    bcd_digit_accumulator #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .bcd_digit    (bcd_digit),
        .digit_last   (digit_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .bin_out      (bin_out),
        .bcd_packed   (bcd_packed),
        .err_invalid  (err_invalid),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level model: decimal and nibble-shifted value of the first NUM_DIGITS digits
    task automatic model(input int digs[$], output int exp_bin, output int exp_pk,
                         output int exp_inv, output int exp_ovf);
        exp_bin = 0;
        exp_pk  = 0;
        exp_inv = 0;
        exp_ovf = (digs.size() > NUM_DIGITS) ? 1 : 0;
        foreach (digs[i]) begin
            int v;
            v = (digs[i] > 9) ? 0 : digs[i];
            if (digs[i] > 9) exp_inv = 1;
            if (i < NUM_DIGITS) begin
                exp_bin = exp_bin * 10 + v;
                exp_pk  = exp_pk * 16 + v;
            end
        end
    endtask

    task automatic wait_ready();
        int cnt;
        cnt = 0;
        while (!digit_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!digit_ready) check("ready_timeout", 32'(digit_ready), 32'd1);
    endtask

    task automatic push_digits(input int digs[$], input bit gaps, input bit mark_last);
        foreach (digs[i]) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                digit_valid = 1'b0;
                @(posedge clk); #1;
            end
            wait_ready();
            digit_valid = 1'b1;
            bcd_digit   = 4'(digs[i]);
            digit_last  = mark_last && (i == digs.size() - 1);
            @(posedge clk); #1;
            if (!(mark_last && (i == digs.size() - 1)))
                check("no_early_valid", 32'(out_valid), 32'd0);
        end
        digit_valid = 1'b0;
        digit_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int eb, input int ep,
                                input int ei, input int eo);
        check({tag, "_bin"}, 32'(bin_out), 32'(eb));
        check({tag, "_pk"},  32'(bcd_packed), 32'(ep));
        check({tag, "_inv"}, 32'(err_invalid), 32'(ei));
        check({tag, "_ovf"}, 32'(err_overflow), 32'(eo));
    endtask

    // Push a frame, check latency, stall for hold_cyc cycles, then hand off
    task automatic run_frame(input string tag, input int digs[$], input int hold_cyc,
                             input bit gaps);
        int eb, ep, ei, eo;
        model(digs, eb, ep, ei, eo);
        push_digits(digs, gaps, 1'b1);
        check({tag, "_latency"}, 32'(out_valid), 32'd1);
        check_result(tag, eb, ep, ei, eo);
        for (int k = 0; k < hold_cyc; k++) begin
            digit_valid = 1'b1;
            bcd_digit   = 4'($urandom_range(0, 9));
            digit_last  = 1'b0;
            @(posedge clk); #1;
            check({tag, "_hold_rdy"}, 32'(digit_ready), 32'd0);
            check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_bin"}, 32'(bin_out), 32'(eb));
            check({tag, "_hold_pk"},  32'(bcd_packed), 32'(ep));
            check({tag, "_hold_err"}, {30'd0, err_invalid, err_overflow},
                  32'((ei << 1) | eo));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        digit_valid = 1'b0;
        out_ready   = 1'b0;
        check({tag, "_drop_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(digit_ready), 32'd1);
        check({tag, "_retain"},   32'(bin_out), 32'(eb));
    endtask

    initial begin
        int q[$];
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        bcd_digit   = 4'd0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_rdy", 32'(digit_ready), 32'd1);
        check_result("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        q = '{1, 2, 3, 4};       run_frame("f1234", q, 0, 1'b0);
        q = '{7};                run_frame("f7", q, 0, 1'b0);
        q = '{9, 9, 9, 9};       run_frame("f9999", q, 0, 1'b0);
        q = '{5, 12, 3};         run_frame("finv", q, 0, 1'b0);
        q = '{2};                run_frame("fclr", q, 0, 1'b0);
        q = '{1, 2, 3, 4, 5};    run_frame("fovf", q, 0, 1'b0);
        q = '{8, 6};             run_frame("fhold", q, 3, 1'b0);
        q = '{1};                run_frame("fnext", q, 0, 1'b0);

        // Reset in the middle of a frame discards it
        q = '{4, 2};
        push_digits(q, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_vld", 32'(out_valid), 32'd0);
        check("midrst_bin", 32'(bin_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_vld2", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        q = '{3};                run_frame("fpostrst", q, 0, 1'b0);

        for (int f = 0; f < 200; f++) begin
            int len;
            q   = {};
            len = int'($urandom_range(1, NUM_DIGITS + 2));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 19) == 0) q.push_back(int'($urandom_range(10, 15)));
                else                            q.push_back(int'($urandom_range(0, 9)));
            end
            run_frame("rnd", q, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
